// File: rtl/nn_cls_pkg.sv
// Shared constants and state type for the classifier operand streamer.
package nn_cls_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int N_FEAT     = 9;
  localparam int ADDR_WIDTH = 4;
  localparam int N_LANES    = 3;
  localparam int FRAC_BITS  = 10;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nn_cls_feat_buf.sv
// Three-lane feature buffer: sample-major write port, parallel 3-lane read at index j.
module nn_cls_feat_buf #(
  parameter int DATA_WIDTH = nn_cls_pkg::DATA_WIDTH,
  parameter int N_FEAT     = nn_cls_pkg::N_FEAT,
  parameter int ADDR_WIDTH = nn_cls_pkg::ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [1:0]            lane_i,
  input  logic [ADDR_WIDTH-1:0] wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_idx_i,
  output logic [DATA_WIDTH-1:0] x1_o,
  output logic [DATA_WIDTH-1:0] x2_o,
  output logic [DATA_WIDTH-1:0] x3_o
);
  import nn_cls_pkg::*;

  logic [DATA_WIDTH-1:0] mem_q [N_LANES][N_FEAT];

  always_ff @(posedge clk_i) begin
    if (we_i && (int'(lane_i) < N_LANES) && (int'(wr_idx_i) < N_FEAT)) begin
      mem_q[lane_i][wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    x1_o = '0;
    x2_o = '0;
    x3_o = '0;
    if (int'(rd_idx_i) < N_FEAT) begin
      x1_o = mem_q[0][rd_idx_i];
      x2_o = mem_q[1][rd_idx_i];
      x3_o = mem_q[2][rd_idx_i];
    end
  end

endmodule

// File: rtl/nn_cls_operand_streamer.sv
// Buffers one batch of three feature vectors plus weights/bias and streams them to the classifier.
// Optional NN_CLS_PINGPONG_EN: double feature buffer so the next batch loads while streaming.
module nn_cls_operand_streamer #(
  parameter int DATA_WIDTH = nn_cls_pkg::DATA_WIDTH,
  parameter int N_FEAT     = nn_cls_pkg::N_FEAT,
  parameter int ADDR_WIDTH = nn_cls_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  w_we,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  b_we,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  cls_done,
  output logic                  start,
  output logic [DATA_WIDTH-1:0] x1j,
  output logic [DATA_WIDTH-1:0] x2j,
  output logic [DATA_WIDTH-1:0] x3j,
  output logic [DATA_WIDTH-1:0] wj,
  output logic [DATA_WIDTH-1:0] b1,
  output logic                  busy,
  output logic [7:0]            batch_cnt
);
  import nn_cls_pkg::*;

  localparam int CNT_W = $clog2(N_FEAT + 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] feat_cnt_q, feat_cnt_d;
  logic [1:0]            lane_cnt_q, lane_cnt_d;
  logic [CNT_W-1:0]      stream_cnt_q, stream_cnt_d;
  logic [7:0]            batch_cnt_q, batch_cnt_d;
  logic [DATA_WIDTH-1:0] w_q [N_FEAT];
  logic [DATA_WIDTH-1:0] w_d [N_FEAT];
  logic [DATA_WIDTH-1:0] bias_q, bias_d;
  logic                  start_q, start_d;
  logic [DATA_WIDTH-1:0] x1_q, x1_d, x2_q, x2_d, x3_q, x3_d, wj_q, wj_d, b1_q, b1_d;

  logic                  accept, last_word, load_op;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] rd_x1, rd_x2, rd_x3;

  assign accept    = in_valid && in_ready;
  assign last_word = accept && (lane_cnt_q == 2'(N_LANES - 1))
                            && (feat_cnt_q == ADDR_WIDTH'(N_FEAT - 1));
  assign rd_idx    = (state_q == STREAM) ? ADDR_WIDTH'(stream_cnt_q) : '0;

`ifdef NN_CLS_PINGPONG_EN
  logic                  front_q, front_d;
  logic                  back_full_q, back_full_d;
  logic                  rd_bank;
  logic [DATA_WIDTH-1:0] b0_x1, b0_x2, b0_x3, b1_x1, b1_x2, b1_x3;

  // Writes always target the back bank; the bank about to be streamed is the back
  // bank on the swap edge and the front bank while streaming.
  assign in_ready = !rst && !back_full_q;
  assign rd_bank  = (state_q == STREAM) ? front_q : ~front_q;
  assign rd_x1    = rd_bank ? b1_x1 : b0_x1;
  assign rd_x2    = rd_bank ? b1_x2 : b0_x2;
  assign rd_x3    = rd_bank ? b1_x3 : b0_x3;

  nn_cls_feat_buf #(.DATA_WIDTH(DATA_WIDTH), .N_FEAT(N_FEAT), .ADDR_WIDTH(ADDR_WIDTH)) u_buf0 (
    .clk_i(clk), .we_i(accept && front_q), .lane_i(lane_cnt_q), .wr_idx_i(feat_cnt_q),
    .wr_data_i(in_data), .rd_idx_i(rd_idx), .x1_o(b0_x1), .x2_o(b0_x2), .x3_o(b0_x3)
  );
  nn_cls_feat_buf #(.DATA_WIDTH(DATA_WIDTH), .N_FEAT(N_FEAT), .ADDR_WIDTH(ADDR_WIDTH)) u_buf1 (
    .clk_i(clk), .we_i(accept && !front_q), .lane_i(lane_cnt_q), .wr_idx_i(feat_cnt_q),
    .wr_data_i(in_data), .rd_idx_i(rd_idx), .x1_o(b1_x1), .x2_o(b1_x2), .x3_o(b1_x3)
  );
`else
  assign in_ready = !rst && (state_q == LOAD);

  nn_cls_feat_buf #(.DATA_WIDTH(DATA_WIDTH), .N_FEAT(N_FEAT), .ADDR_WIDTH(ADDR_WIDTH)) u_buf (
    .clk_i(clk), .we_i(accept), .lane_i(lane_cnt_q), .wr_idx_i(feat_cnt_q),
    .wr_data_i(in_data), .rd_idx_i(rd_idx), .x1_o(rd_x1), .x2_o(rd_x2), .x3_o(rd_x3)
  );
`endif

  always_comb begin
    state_d      = state_q;
    feat_cnt_d   = feat_cnt_q;
    lane_cnt_d   = lane_cnt_q;
    stream_cnt_d = stream_cnt_q;
    batch_cnt_d  = batch_cnt_q;
    w_d          = w_q;
    bias_d       = bias_q;
    load_op      = 1'b0;
    start_d      = 1'b0;
    x1_d         = '0;
    x2_d         = '0;
    x3_d         = '0;
    wj_d         = '0;
    b1_d         = '0;
`ifdef NN_CLS_PINGPONG_EN
    front_d      = front_q;
    back_full_d  = back_full_q;
    if (last_word && (state_q != LOAD)) back_full_d = 1'b1;
`endif

    if (state_q != STREAM) begin
      if (w_we && (int'(w_addr) < N_FEAT)) w_d[w_addr] = w_data;
      if (b_we) bias_d = b_data;
    end

    if (accept) begin
      if (feat_cnt_q == ADDR_WIDTH'(N_FEAT - 1)) begin
        feat_cnt_d = '0;
        lane_cnt_d = (lane_cnt_q == 2'(N_LANES - 1)) ? 2'd0 : lane_cnt_q + 2'd1;
      end else begin
        feat_cnt_d = feat_cnt_q + ADDR_WIDTH'(1);
      end
    end

    // Index 0 is launched on the entry edge so start rises the cycle after the last word.
    unique case (state_q)
      LOAD: begin
        if (last_word) begin
          state_d      = STREAM;
          load_op      = 1'b1;
          stream_cnt_d = CNT_W'(1);
`ifdef NN_CLS_PINGPONG_EN
          front_d      = ~front_q;
`endif
        end
      end
      STREAM: begin
        if (stream_cnt_q == CNT_W'(N_FEAT)) begin
          state_d      = WAIT_DONE;
          stream_cnt_d = '0;
        end else begin
          load_op      = 1'b1;
          stream_cnt_d = stream_cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (cls_done) begin
          batch_cnt_d  = batch_cnt_q + 8'd1;
          stream_cnt_d = '0;
`ifdef NN_CLS_PINGPONG_EN
          if (back_full_q || last_word) begin
            state_d      = STREAM;
            load_op      = 1'b1;
            stream_cnt_d = CNT_W'(1);
            front_d      = ~front_q;
            back_full_d  = 1'b0;
          end else begin
            state_d      = LOAD;
          end
`else
          feat_cnt_d   = '0;
          lane_cnt_d   = '0;
          state_d      = LOAD;
`endif
        end
      end
      default: state_d = LOAD;
    endcase

    if (load_op) begin
      start_d = 1'b1;
      x1_d    = rd_x1;
      x2_d    = rd_x2;
      x3_d    = rd_x3;
      wj_d    = (int'(rd_idx) < N_FEAT) ? w_d[rd_idx] : '0;
      b1_d    = bias_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      feat_cnt_q   <= '0;
      lane_cnt_q   <= '0;
      stream_cnt_q <= '0;
      batch_cnt_q  <= '0;
      w_q          <= '{default: '0};
      bias_q       <= '0;
      start_q      <= 1'b0;
      x1_q         <= '0;
      x2_q         <= '0;
      x3_q         <= '0;
      wj_q         <= '0;
      b1_q         <= '0;
`ifdef NN_CLS_PINGPONG_EN
      front_q      <= 1'b0;
      back_full_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      feat_cnt_q   <= feat_cnt_d;
      lane_cnt_q   <= lane_cnt_d;
      stream_cnt_q <= stream_cnt_d;
      batch_cnt_q  <= batch_cnt_d;
      w_q          <= w_d;
      bias_q       <= bias_d;
      start_q      <= start_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      x3_q         <= x3_d;
      wj_q         <= wj_d;
      b1_q         <= b1_d;
`ifdef NN_CLS_PINGPONG_EN
      front_q      <= front_d;
      back_full_q  <= back_full_d;
`endif
    end
  end

  assign start     = start_q;
  assign x1j       = x1_q;
  assign x2j       = x2_q;
  assign x3j       = x3_q;
  assign wj        = wj_q;
  assign b1        = b1_q;
  assign busy      = (state_q != LOAD);
  assign batch_cnt = batch_cnt_q;

endmodule

// File: tb/tb_nn_cls_operand_streamer.sv
// Directed self-checking bench for nn_cls_operand_streamer (honours NN_CLS_PINGPONG_EN).
module tb_nn_cls_operand_streamer;

`ifdef NN_CLS_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  logic        clk, rst, in_valid, in_ready, w_we, b_we, cls_done, start, busy;
  logic [15:0] in_data, w_data, b_data, x1j, x2j, x3j, wj, b1;
  logic [3:0]  w_addr;
  logic [7:0]  batch_cnt;

  int errors = 0;
  int checks = 0;

  logic [15:0] W  [9] = '{16'h034C, 16'h064F, 16'h067D, 16'h048A, 16'h044F,
                          16'h03C9, 16'h0563, 16'h04BA, 16'h069D};
  logic [15:0] W2 [9] = '{16'h034C, 16'h064F, 16'h7FFF, 16'h048A, 16'h044F,
                          16'h03C9, 16'h0563, 16'h04BA, 16'h069D};

  nn_cls_operand_streamer #(.DATA_WIDTH(16), .N_FEAT(9), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .b_we(b_we), .b_data(b_data),
    .cls_done(cls_done), .start(start), .x1j(x1j), .x2j(x2j), .x3j(x3j), .wj(wj),
    .b1(b1), .busy(busy), .batch_cnt(batch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Batch A: lane1 = 0, lane2 = j<<10, lane3 = -1.0
  function automatic logic [15:0] val_a(input int n);
    logic [15:0] j;
    j = 16'(n % 9);
    if (n < 9) return 16'h0000;
    if (n < 18) return j << 10;
    return 16'hFC00;
  endfunction

  // Batch B: a distinct value per word so drops/duplicates are visible
  function automatic logic [15:0] val_b(input int n);
    return 16'(32'h8000 + n * 32'h0111);
  endfunction

  task automatic load_a();
    for (int n = 0; n < 27; n++) begin
      in_valid = 1'b1;
      in_data  = val_a(n);
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_data = '0; w_we = 0; w_addr = '0; w_data = '0;
    b_we = 0; b_data = '0; cls_done = 0;
    tick(); tick();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (batch_cnt !== 8'd0) begin errors++; $display("FAIL reset_batch: got %0d want 0", batch_cnt); end
    checks++; if ({x1j, x2j, x3j, wj, b1} !== 80'd0) begin errors++; $display("FAIL reset_ops: got %h want 0", {x1j, x2j, x3j, wj, b1}); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic_stream();
    for (int j = 0; j < 9; j++) begin
      w_we = 1'b1; w_addr = 4'(j); w_data = W[j];
      b_we = (j == 0); b_data = 16'hF3A3;
      tick();
    end
    w_we = 1'b0; b_we = 1'b0;
    for (int n = 0; n < 27; n++) begin
      in_valid = 1'b1;
      in_data  = val_a(n);
      tick();
      if (n == 25) begin
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL early_start: got %b want 0", start); end
      end
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== PP) begin errors++; $display("FAIL in_ready_after_load: got %b want %b", in_ready, PP); end
    // Weight write at k=0 must be dropped; cls_done at k=3 must be ignored
    for (int k = 0; k < 9; k++) begin
      w_we = (k == 0); w_addr = 4'd2; w_data = 16'h7FFF;
      cls_done = (k == 3);
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL basic_start_k%0d: got %b want 1", k, start); end
      checks++; if (x1j !== 16'h0000) begin errors++; $display("FAIL basic_x1_k%0d: got %h want 0000", k, x1j); end
      checks++; if (x2j !== 16'(k << 10)) begin errors++; $display("FAIL basic_x2_k%0d: got %h want %h", k, x2j, 16'(k << 10)); end
      checks++; if (x3j !== 16'hFC00) begin errors++; $display("FAIL basic_x3_k%0d: got %h want fc00", k, x3j); end
      checks++; if (wj !== W[k]) begin errors++; $display("FAIL basic_wj_k%0d: got %h want %h", k, wj, W[k]); end
      checks++; if (b1 !== 16'hF3A3) begin errors++; $display("FAIL basic_b1_k%0d: got %h want f3a3", k, b1); end
      tick();
    end
    w_we = 1'b0; cls_done = 1'b0;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL basic_start_end: got %b want 0", start); end
    checks++; if ({x1j, x2j, x3j, wj, b1} !== 80'd0) begin errors++; $display("FAIL basic_ops_end: got %h want 0", {x1j, x2j, x3j, wj, b1}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_end: got %b want 1", busy); end
    checks++; if (batch_cnt !== 8'd0) begin errors++; $display("FAIL done_ignored_stream: got %0d want 0", batch_cnt); end
  endtask

  task automatic test_done_handshake();
    for (int i = 0; i < 4; i++) begin
      w_we = (i == 1) || (i == 2);
      w_addr = (i == 1) ? 4'd2 : 4'd12;
      w_data = (i == 1) ? 16'h7FFF : 16'h1234;
      b_we = (i == 1); b_data = 16'h0C5D;
      tick();
    end
    w_we = 1'b0; b_we = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy: got %b want 1", busy); end
    checks++; if (in_ready !== PP) begin errors++; $display("FAIL wait_in_ready: got %b want %b", in_ready, PP); end
    checks++; if (batch_cnt !== 8'd0) begin errors++; $display("FAIL wait_batch: got %0d want 0", batch_cnt); end
    cls_done = 1'b1;
    tick();
    cls_done = 1'b0;
    checks++; if (batch_cnt !== 8'd1) begin errors++; $display("FAIL done_batch: got %0d want 1", batch_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL done_in_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int n;
    n = 0;
    for (int c = 0; c < 200 && n < 27; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = in_valid ? val_b(n) : 16'hDEAD;
      tick();
      if (in_valid) n++;
    end
    in_valid = 1'b0;
    checks++; if (n !== 27) begin errors++; $display("FAIL bp_words: got %0d want 27", n); end
    checks++; if (in_ready !== PP) begin errors++; $display("FAIL bp_in_ready: got %b want %b", in_ready, PP); end
    for (int k = 0; k < 9; k++) begin
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL bp_start_k%0d: got %b want 1", k, start); end
      checks++; if (x1j !== val_b(k)) begin errors++; $display("FAIL bp_x1_k%0d: got %h want %h", k, x1j, val_b(k)); end
      checks++; if (x2j !== val_b(9 + k)) begin errors++; $display("FAIL bp_x2_k%0d: got %h want %h", k, x2j, val_b(9 + k)); end
      checks++; if (x3j !== val_b(18 + k)) begin errors++; $display("FAIL bp_x3_k%0d: got %h want %h", k, x3j, val_b(18 + k)); end
      checks++; if (wj !== W2[k]) begin errors++; $display("FAIL bp_wj_k%0d: got %h want %h", k, wj, W2[k]); end
      checks++; if (b1 !== 16'h0C5D) begin errors++; $display("FAIL bp_b1_k%0d: got %h want 0c5d", k, b1); end
      tick();
    end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL bp_start_end: got %b want 0", start); end
    cls_done = 1'b1;
    tick();
    cls_done = 1'b0;
    checks++; if (batch_cnt !== 8'd2) begin errors++; $display("FAIL bp_batch: got %0d want 2", batch_cnt); end
  endtask

  task automatic test_reset_midstream();
    load_a();
    for (int k = 0; k < 5; k++) begin
      checks++; if (x2j !== 16'(k << 10)) begin errors++; $display("FAIL rs_x2_k%0d: got %h want %h", k, x2j, 16'(k << 10)); end
      rst = (k == 4);
      tick();
    end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rs_start: got %b want 0", start); end
    checks++; if ({x1j, x2j, x3j, wj, b1} !== 80'd0) begin errors++; $display("FAIL rs_ops: got %h want 0", {x1j, x2j, x3j, wj, b1}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rs_busy: got %b want 0", busy); end
    checks++; if (batch_cnt !== 8'd0) begin errors++; $display("FAIL rs_batch: got %0d want 0", batch_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rs_in_ready: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rs_load_ready: got %b want 1", in_ready); end
    for (int n = 0; n < 27; n++) begin
      in_valid = 1'b1;
      in_data  = val_b(n);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      checks++; if (x1j !== val_b(k)) begin errors++; $display("FAIL rs_x1_k%0d: got %h want %h", k, x1j, val_b(k)); end
      checks++; if (x3j !== val_b(18 + k)) begin errors++; $display("FAIL rs_x3_k%0d: got %h want %h", k, x3j, val_b(18 + k)); end
      checks++; if (wj !== 16'h0000) begin errors++; $display("FAIL rs_wj_cleared_k%0d: got %h want 0000", k, wj); end
      checks++; if (b1 !== 16'h0000) begin errors++; $display("FAIL rs_b1_cleared_k%0d: got %h want 0000", k, b1); end
      tick();
    end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rs_start_end: got %b want 0", start); end
  endtask

`ifdef NN_CLS_PINGPONG_EN
  task automatic test_pingpong();
    for (int j = 0; j < 9; j++) begin
      w_we = 1'b1; w_addr = 4'(j); w_data = W[j];
      b_we = (j == 0); b_data = 16'hF3A3;
      tick();
    end
    w_we = 1'b0; b_we = 1'b0;
    load_a();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pp_back_full: got %b want 0", in_ready); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL pp_no_start: got %b want 0", start); end
    cls_done = 1'b1;
    tick();
    cls_done = 1'b0;
    checks++; if (batch_cnt !== 8'd1) begin errors++; $display("FAIL pp_batch: got %0d want 1", batch_cnt); end
    for (int k = 0; k < 9; k++) begin
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL pp_start_k%0d: got %b want 1", k, start); end
      checks++; if (x2j !== 16'(k << 10)) begin errors++; $display("FAIL pp_x2_k%0d: got %h want %h", k, x2j, 16'(k << 10)); end
      checks++; if (x3j !== 16'hFC00) begin errors++; $display("FAIL pp_x3_k%0d: got %h want fc00", k, x3j); end
      checks++; if (wj !== W[k]) begin errors++; $display("FAIL pp_wj_k%0d: got %h want %h", k, wj, W[k]); end
      tick();
    end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL pp_start_end: got %b want 0", start); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_stream();
    test_done_handshake();
    test_backpressure();
    test_reset_midstream();
`ifdef NN_CLS_PINGPONG_EN
    test_pingpong();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nn_cls_operand_streamer.md
Name: nn_cls_operand_streamer

Overview:
Upstream feeder for the forward-NN classification stage.
- Buffers one batch of three 9-element latent feature vectors (Q6.10, 16-bit), plus the 9 classifier weights and the bias.
- Streams them one index j per cycle as x1j/x2j/x3j/wj/b1, with start held high for 9 consecutive cycles.
- Waits for the classifier's done before releasing the next batch.
- Sits between the VAE encoder output and top_forward_nn_classification.

Parameters:
- DATA_WIDTH, 16: operand width, signed Q6.10.
- N_FEAT, 9: features per vector; number of stream cycles.
- ADDR_WIDTH, 4: weight address width; must satisfy 2^ADDR_WIDTH >= N_FEAT.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: feature word valid.
- in_ready, out, 1: streamer accepts a feature word this cycle.
- in_data, in, DATA_WIDTH: feature word, signed.
- w_we, in, 1: weight write strobe.
- w_addr, in, ADDR_WIDTH: weight index j.
- w_data, in, DATA_WIDTH: weight value.
- b_we, in, 1: bias write strobe.
- b_data, in, DATA_WIDTH: bias value.
- cls_done, in, 1: done from the classifier.
- start, out, 1: classifier start; high exactly N_FEAT cycles per batch.
- x1j / x2j / x3j, out, DATA_WIDTH each: lane 1/2/3 feature at index j.
- wj, out, DATA_WIDTH: weight at index j.
- b1, out, DATA_WIDTH: bias, constant for the whole stream.
- busy, out, 1: high in STREAM or WAIT_DONE.
- batch_cnt, out, 8: batches completed, wraps 255 -> 0.

Behaviour:
- Reset (sync, rst=1 at edge): state LOAD; lane/feature/stream counters 0; all outputs 0; in_ready=0 during the reset cycle; weight and bias registers cleared to 0. Reset mid-stream drops start at that same edge; the partial batch is discarded.
- States: LOAD -> STREAM -> WAIT_DONE -> LOAD.
- LOAD:
  - in_ready=1.
  - A word is accepted when in_valid & in_ready. Order is sample-major: words 0-8 go to lane1 j=0..8, 9-17 to lane2, 18-26 to lane3.
  - feat_cnt wraps 8 -> 0 and increments lane_cnt.
  - On acceptance of word 26: in_ready=0 from the next cycle, and the state goes to STREAM at the next edge.
  - in_valid=0 cycles stall with no counter change.
- STREAM:
  - All outputs are registered. Cycle k (k=0..8) presents start=1, x1j=buf[0][k], x2j=buf[1][k], x3j=buf[2][k], wj=w[k], b1=bias.
  - After k=8 the state moves to WAIT_DONE. start=0 and all operands are 0 from that cycle.
- Latency: first start cycle = the cycle after word 26 is accepted. Inputs to the classifier are stable for the full clock period.
- WAIT_DONE: hold outputs 0. On cls_done=1: increment batch_cnt, clear counters, go to LOAD.
- cls_done while in LOAD or STREAM: ignored.
- Weight/bias writes:
  - Take effect at the next edge when state != STREAM.
  - Writes during STREAM are dropped, so weights are frozen per batch.
  - w_addr >= N_FEAT: write ignored.
  - w_we and b_we in the same cycle: both are applied.
- No arithmetic: data passes through unmodified. Sign and Q6.10 format are preserved bit-exact.

Optional Feature:
NN_CLS_PINGPONG_EN
- Defined:
  - Two feature buffers (front/back). in_ready stays high in every state while the back buffer is not full, so the next batch loads during STREAM/WAIT_DONE.
  - On cls_done with the back buffer full: swap buffers and enter STREAM at the next edge, skipping LOAD.
  - On cls_done with the back buffer not full: go to LOAD and continue filling.
  - The state machine is identical otherwise.
- Undefined: single buffer; in_ready=0 outside LOAD.

Decomposition:
- Shared package nn_cls_pkg:
  - DATA_WIDTH, N_FEAT, N_LANES=3.
  - Q6.10 FRAC_BITS=10.
  - State enum {LOAD, STREAM, WAIT_DONE}.
- One natural sub-module, nn_cls_feat_buf: a 3x N_FEAT register array with sample-major write port and parallel 3-lane read at index j. It is instantiated twice under NN_CLS_PINGPONG_EN.

Test Plan:
- Basic stream:
  - Setup: weights j=0..8 = 0x034C, 0x064F, 0x067D, 0x048A, 0x044F, 0x03C9, 0x0563, 0x04BA, 0x069D; bias 0xF3A3; 27 words with lane1=0x0000, lane2=j<<10, lane3=0xFC00 (-1.0).
  - Expect start high exactly 9 cycles starting the cycle after word 26; at k=4: x2j=0x1000, x3j=0xFC00, wj=0x044F; b1=0xF3A3 throughout.
- Backpressure: in_valid toggled 1,0,1,0 during load -> 27 accepts total, no duplicate or skipped word; in_ready=0 after the 27th accept.
- Done handshake: cls_done pulsed in STREAM k=3 -> ignored. Pulse 5 cycles after stream end -> batch_cnt 0->1, in_ready=1 the next cycle.
- Frozen weights: w_we to j=2 with 0x7FFF during STREAM -> wj at k=2 unchanged (0x067D). The same write in WAIT_DONE -> next batch shows 0x7FFF; w_addr=12 ignored.
- Reset mid-stream: rst at k=5 -> start=0 and all outputs 0 at that edge; weights cleared; state LOAD.
- With NN_CLS_PINGPONG_EN: second batch loaded fully during WAIT_DONE -> start reasserts the cycle after cls_done with the second batch's data.
